mem_burst_arbiter: RTL and testbench

//  Sequences block (cache-line) transfers to the single-port simulation memory for two requesters:
//  I-cache (read-only refill) and D-cache (refill or write-back). Grants one requester at a time

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_burst_arbiter_if.sv | 59 +++++
 rtl/mem_arb_rr.sv | 36 +++
 rtl/mem_burst_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the memory burst arbiter: FSM state encoding and the
// identity of the requester that currently owns the memory port.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_burst_arbiter_if
// Bundles the I-cache, D-cache and mem_sim sides of the burst arbiter.
//   I-cache : ic_req, ic_addr -> ic_rdata, ic_rvalid, ic_idx, ic_done
//   D-cache : dc_req, dc_we, dc_addr, dc_wdata -> dc_rdata, dc_rvalid,
//             dc_idx, dc_done
//   memory  : mem_write_en, mem_access, mem_addr, mem_wdata <- mem_rdata
// Modports:
//   slave  - the arbiter itself
//   master - the environment (caches plus memory model)
// ---------------------------------------------------------------------------
interface mem_burst_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WORDS = 16
);
    localparam int IW = $clog2(BLOCK_WORDS);

    logic                  ic_req;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic [DATA_WIDTH-1:0] ic_rdata;
    logic                  ic_rvalid;
    logic [IW-1:0]         ic_idx;
    logic                  ic_done;

    logic                  dc_req;
    logic                  dc_we;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [DATA_WIDTH-1:0] dc_wdata;
    logic [DATA_WIDTH-1:0] dc_rdata;
    logic                  dc_rvalid;
    logic [IW-1:0]         dc_idx;
    logic                  dc_done;

    logic                  mem_write_en;
    logic                  mem_access;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  ic_req, ic_addr,
        output ic_rdata, ic_rvalid, ic_idx, ic_done,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output dc_rdata, dc_rvalid, dc_idx, dc_done,
        output mem_write_en, mem_access, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ic_req, ic_addr,
        input  ic_rdata, ic_rvalid, ic_idx, ic_done,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  dc_rdata, dc_rvalid, dc_idx, dc_done,
        input  mem_write_en, mem_access, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr
// Two-way round-robin pick between the I-cache and D-cache requests.
// Purely combinational; the last_grant history lives in the top level.
//   ic_req_i     in   I-cache request
//   dc_req_i     in   D-cache request
//   last_grant_i in   owner of the previous completed burst
//   valid_o      out  at least one request is pending
//   owner_o      out  requester to grant (meaningful when valid_o)
// ---------------------------------------------------------------------------
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       ic_req_i,
    input  logic       dc_req_i,
    input  arb_owner_t last_grant_i,
    output logic       valid_o,
    output arb_owner_t owner_o
);

    // NOTE: every output gets a default before the decisions below, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        valid_o = ic_req_i | dc_req_i;
        owner_o = OWN_I;
        if (ic_req_i && dc_req_i) begin
            // On a tie the requester that was not served last wins.
            if (last_grant_i == OWN_I) begin
                owner_o = OWN_D;
            end
        end else if (dc_req_i) begin
            owner_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// mem_burst_arbiter
// Sequences cache-line transfers to the single-port mem_sim for the I-cache
// (refill only) and the D-cache (refill or write-back). One requester is
// granted at a time, WAIT_CYCLES of access latency follow, then
// BLOCK_WORDS words stream at one word per cycle and a one-cycle done pulse
// closes the burst.
//   clk    in  clock
//   arstn  in  asynchronous active-low reset
//   bus    mem_burst_arbiter_if.slave - cache request/response signals and
//          the mem_sim port (see the interface header)
// ---------------------------------------------------------------------------
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WORDS = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    mem_burst_arbiter_if.slave    bus
);

    localparam int IW  = $clog2(BLOCK_WORDS);
    // Bits below LB address a byte inside the line; the rest is the line.
    localparam int LB  = IW + 2;
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    arb_state_t              state_q,      state_d;
    arb_owner_t              owner_q,      owner_d;
    arb_owner_t              last_grant_q, last_grant_d;
    logic                    we_q,         we_d;
    logic [ADDR_WIDTH-LB-1:0] base_q,      base_d;
    logic [WCW-1:0]          wait_cnt_q,   wait_cnt_d;
    logic [IW-1:0]           beat_q,       beat_d;

    logic       grant_valid;
    arb_owner_t grant_owner;

    mem_arb_rr u_rr (
        .ic_req_i     (bus.ic_req),
        .dc_req_i     (bus.dc_req),
        .last_grant_i (last_grant_q),
        .valid_o      (grant_valid),
        .owner_o      (grant_owner)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        base_d       = base_q;
        wait_cnt_d   = wait_cnt_q;
        beat_d       = beat_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    beat_d  = '0;
                    if (grant_owner == OWN_D) begin
                        we_d   = bus.dc_we;
                        base_d = bus.dc_addr[ADDR_WIDTH-1:LB];
                    end else begin
                        we_d   = 1'b0;
                        base_d = bus.ic_addr[ADDR_WIDTH-1:LB];
                    end
                    if (WAIT_CYCLES == 0) begin
                        state_d = XFER;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WCW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - WCW'(1);
                if (wait_cnt_q == WCW'(1)) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                beat_d = beat_q + IW'(1);
                if (beat_q == IW'(BLOCK_WORDS - 1)) begin
                    state_d      = DONE;
                    last_grant_d = owner_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            we_q         <= 1'b0;
            base_q       <= '0;
            wait_cnt_q   <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            base_q       <= base_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_q       <= beat_d;
        end
    end

    // ------------------------------------------------------------- outputs
    // Everything below decodes registered state only (plus the two data
    // pass-throughs), so mem_write_en cannot glitch on a state change and
    // an asynchronous reset clears every output immediately.
    logic in_xfer;
    logic own_d;
    logic write_beat;

    assign in_xfer    = (state_q == XFER);
    assign own_d      = (owner_q == OWN_D);
    assign write_beat = in_xfer & we_q;

    // The beat index is spliced in, so the offset can never carry into the
    // line-address field.
    assign bus.mem_addr     = in_xfer ? {base_q, beat_q, 2'b00} : '0;
    assign bus.mem_access   = in_xfer & own_d;
    assign bus.mem_write_en = write_beat;
    assign bus.mem_wdata    = write_beat ? bus.dc_wdata : '0;

    assign bus.ic_rvalid = in_xfer & ~own_d;
    assign bus.ic_idx    = bus.ic_rvalid ? beat_q : '0;
    assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
    assign bus.ic_done   = (state_q == DONE) & ~own_d;

    assign bus.dc_rvalid = in_xfer & own_d & ~we_q;
    // dc_idx also runs during write-backs: it selects dc_wdata.
    assign bus.dc_idx    = (in_xfer & own_d) ? beat_q : '0;
    assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;
    assign bus.dc_done   = (state_q == DONE) & own_d;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_arbiter
// Directed bench for mem_burst_arbiter (BLOCK_WORDS=16, WAIT_CYCLES=2) with
// a small mem_sim model: separate instruction and data word arrays,
// combinational read, write on the clock edge that ends a write beat.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_burst_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int BW = 16;
    localparam int WC = 2;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    mem_burst_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) bus ();

    mem_burst_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BLOCK_WORDS(BW),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    // ------------------------------------------------------- memory model
    logic [31:0] mem_i [0:255];
    logic [31:0] mem_d [0:255];
    logic [31:0] wbase;

    assign bus.dc_wdata  = wbase + 32'(bus.dc_idx);
    assign bus.mem_rdata = bus.mem_access ? mem_d[bus.mem_addr[9:2]]
                                          : mem_i[bus.mem_addr[9:2]];

    initial begin
        for (int w = 0; w < 256; w++) begin
            mem_i[w] = 32'h1000_0000 + 32'(w);
            mem_d[w] = 32'h2000_0000 + 32'(w);
        end
        for (int w = 0; w < 16; w++) begin
            mem_d[128 + w] = 32'h0000_5500 + 32'(w);
        end
        forever begin
            @(posedge clk);
            if (bus.mem_write_en) begin
                if (bus.mem_access) mem_d[bus.mem_addr[9:2]] <= bus.mem_wdata;
                else                mem_i[bus.mem_addr[9:2]] <= bus.mem_wdata;
            end
        end
    end

    // ------------------------------------------------------------ helpers
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [173:0] outs();
        return {bus.ic_rdata, bus.ic_rvalid, bus.ic_idx, bus.ic_done,
                bus.dc_rdata, bus.dc_rvalid, bus.dc_idx, bus.dc_done,
                bus.mem_write_en, bus.mem_access, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance until a beat is visible (read or write); bounded.
    task automatic wait_beat(output int cyc);
        cyc = 0;
        while (!(bus.ic_rvalid || bus.dc_rvalid || bus.mem_write_en) && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Advance until a done pulse is visible; bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!(bus.ic_done || bus.dc_done) && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        int cyc;
        tick();
        tick();
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        arstn = 1'b1;
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        // Mid-burst reset: outputs must clear without waiting for an edge.
        bus.ic_addr = 64'h0;
        bus.ic_req  = 1'b1;
        wait_beat(cyc);
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.ic_rvalid !== 1'b1 || bus.ic_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_pre_beat3: rvalid %0b idx %0d want 1/3", bus.ic_rvalid, bus.ic_idx);
        end
        #2 arstn = 1'b0;
        #1;
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_async_clear: got %h want 0", outs());
        end
        bus.ic_req = 1'b0;
        tick();
        arstn = 1'b1;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE || outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_release: state %0d outs %h want IDLE/0", dut.state_q, outs());
        end
    endtask

    task automatic test_i_refill();
        int cyc;
        bus.ic_addr = 64'h44;
        bus.ic_req  = 1'b1;
        wait_beat(cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL i_latency: got %0d want 3", cyc);
        end
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if ({bus.ic_rvalid, bus.ic_idx, bus.mem_access, bus.mem_write_en, bus.dc_rvalid}
                !== {1'b1, 4'(k), 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL i_ctrl beat %0d: rvalid %0b idx %0d acc %0b we %0b dvalid %0b", k,
                         bus.ic_rvalid, bus.ic_idx, bus.mem_access, bus.mem_write_en, bus.dc_rvalid);
            end
            n_checks++;
            if (bus.mem_addr !== 64'h40 + 64'(4 * k)) begin
                n_fail++;
                $display("FAIL i_addr beat %0d: got %h want %h", k, bus.mem_addr, 64'h40 + 64'(4 * k));
            end
            n_checks++;
            if (bus.ic_rdata !== 32'h1000_0010 + 32'(k)) begin
                n_fail++;
                $display("FAIL i_data beat %0d: got %h want %h", k, bus.ic_rdata, 32'h1000_0010 + 32'(k));
            end
            tick();
        end
        n_checks++;
        if ({bus.ic_done, bus.dc_done, bus.ic_rvalid} !== 3'b100 || bus.mem_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL i_done: done %0b/%0b rvalid %0b addr %h want 1/0/0/0",
                     bus.ic_done, bus.dc_done, bus.ic_rvalid, bus.mem_addr);
        end
        bus.ic_req = 1'b0;
        tick();
        n_checks++;
        if (bus.ic_done !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL i_after_done: done %0b state %0d want 0/IDLE", bus.ic_done, dut.state_q);
        end
    endtask

    task automatic test_d_writeback();
        int cyc;
        wbase       = 32'h0000_A000;
        bus.dc_we   = 1'b1;
        bus.dc_addr = 64'h100;
        bus.dc_req  = 1'b1;
        wait_beat(cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL wb_latency: got %0d want 3", cyc);
        end
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if ({bus.mem_write_en, bus.mem_access, bus.dc_idx, bus.dc_rvalid, bus.ic_rvalid}
                !== {1'b1, 1'b1, 4'(k), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL wb_ctrl beat %0d: we %0b acc %0b idx %0d dvalid %0b ivalid %0b", k,
                         bus.mem_write_en, bus.mem_access, bus.dc_idx, bus.dc_rvalid, bus.ic_rvalid);
            end
            n_checks++;
            if (bus.mem_addr !== 64'h100 + 64'(4 * k) || bus.mem_wdata !== 32'hA000 + 32'(k)) begin
                n_fail++;
                $display("FAIL wb_bus beat %0d: addr %h data %h want %h/%h", k, bus.mem_addr,
                         bus.mem_wdata, 64'h100 + 64'(4 * k), 32'hA000 + 32'(k));
            end
            tick();
        end
        n_checks++;
        if (bus.dc_done !== 1'b1 || bus.mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_done: done %0b we %0b want 1/0", bus.dc_done, bus.mem_write_en);
        end
        bus.dc_req = 1'b0;
        tick();
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if (mem_d[64 + k] !== 32'hA000 + 32'(k)) begin
                n_fail++;
                $display("FAIL wb_mem word %0d: got %h want %h", k, mem_d[64 + k], 32'hA000 + 32'(k));
            end
        end
        // Refill of the same line from an address near its end.
        bus.dc_we   = 1'b0;
        bus.dc_addr = 64'h13C;
        bus.dc_req  = 1'b1;
        wait_beat(cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL rf_latency: got %0d want 3", cyc);
        end
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if ({bus.dc_rvalid, bus.dc_idx, bus.mem_write_en} !== {1'b1, 4'(k), 1'b0} ||
                bus.mem_addr !== 64'h100 + 64'(4 * k) || bus.dc_rdata !== 32'hA000 + 32'(k)) begin
                n_fail++;
                $display("FAIL rf_beat %0d: valid %0b idx %0d addr %h data %h want 1/%0d/%h/%h", k,
                         bus.dc_rvalid, bus.dc_idx, bus.mem_addr, bus.dc_rdata, k,
                         64'h100 + 64'(4 * k), 32'hA000 + 32'(k));
            end
            tick();
        end
        n_checks++;
        if (bus.dc_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rf_done: got %0b want 1", bus.dc_done);
        end
        bus.dc_req = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        int cyc;
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        bus.ic_addr = 64'h0;
        bus.dc_addr = 64'h80;
        bus.dc_we   = 1'b0;
        bus.ic_req  = 1'b1;
        bus.dc_req  = 1'b1;
        wait_beat(cyc);
        n_checks++;
        if ({bus.dc_rvalid, bus.ic_rvalid} !== 2'b10 || bus.dc_rdata !== 32'h2000_0020) begin
            n_fail++;
            $display("FAIL tie1_first: dvalid %0b ivalid %0b data %h want 1/0/20000020",
                     bus.dc_rvalid, bus.ic_rvalid, bus.dc_rdata);
        end
        wait_done(cyc);
        n_checks++;
        if (bus.dc_done !== 1'b1 || cyc != 16) begin
            n_fail++;
            $display("FAIL tie1_d_done: done %0b cycles %0d want 1/16", bus.dc_done, cyc);
        end
        bus.dc_req = 1'b0;
        wait_beat(cyc);
        n_checks++;
        if (bus.ic_rvalid !== 1'b1 || cyc != 4 || bus.ic_rdata !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL tie1_second: ivalid %0b cycles %0d data %h want 1/4/10000000",
                     bus.ic_rvalid, cyc, bus.ic_rdata);
        end
        wait_done(cyc);
        bus.ic_req = 1'b0;
        // A lone D burst leaves last_grant = D.
        bus.dc_addr = 64'hC0;
        bus.dc_req  = 1'b1;
        wait_beat(cyc);
        wait_done(cyc);
        bus.dc_req = 1'b0;
        tick();
        bus.ic_req = 1'b1;
        bus.dc_req = 1'b1;
        wait_beat(cyc);
        n_checks++;
        if ({bus.ic_rvalid, bus.dc_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie2_first: ivalid %0b dvalid %0b want 1/0", bus.ic_rvalid, bus.dc_rvalid);
        end
        wait_done(cyc);
        n_checks++;
        if (bus.ic_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tie2_i_done: got %0b want 1", bus.ic_done);
        end
        bus.ic_req = 1'b0;
        wait_beat(cyc);
        n_checks++;
        if (bus.dc_rvalid !== 1'b1 || cyc != 4) begin
            n_fail++;
            $display("FAIL tie2_second: dvalid %0b cycles %0d want 1/4", bus.dc_rvalid, cyc);
        end
        wait_done(cyc);
        bus.dc_req = 1'b0;
        tick();
    endtask

    task automatic test_late_request();
        int cyc;
        bus.ic_addr = 64'h80;
        bus.dc_addr = 64'hC0;
        bus.dc_we   = 1'b0;
        bus.ic_req  = 1'b1;
        wait_beat(cyc);
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if ({bus.ic_rvalid, bus.ic_idx, bus.dc_rvalid, bus.mem_access} !== {1'b1, 4'(k), 1'b0, 1'b0} ||
                bus.ic_rdata !== 32'h1000_0020 + 32'(k)) begin
                n_fail++;
                $display("FAIL late_i_beat %0d: valid %0b idx %0d dvalid %0b acc %0b data %h", k,
                         bus.ic_rvalid, bus.ic_idx, bus.dc_rvalid, bus.mem_access, bus.ic_rdata);
            end
            if (k == 7) bus.dc_req = 1'b1;
            tick();
        end
        n_checks++;
        if ({bus.ic_done, bus.dc_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL late_i_done: ic %0b dc %0b want 1/0", bus.ic_done, bus.dc_done);
        end
        bus.ic_req = 1'b0;
        tick();
        n_checks++;
        if (dut.state_q !== IDLE || bus.dc_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL late_idle: state %0d dvalid %0b want IDLE/0", dut.state_q, bus.dc_rvalid);
        end
        wait_beat(cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL late_d_latency: got %0d want 3", cyc);
        end
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if ({bus.dc_rvalid, bus.dc_idx} !== {1'b1, 4'(k)} || bus.dc_rdata !== 32'h2000_0030 + 32'(k)) begin
                n_fail++;
                $display("FAIL late_d_beat %0d: valid %0b idx %0d data %h want 1/%0d/%h", k,
                         bus.dc_rvalid, bus.dc_idx, bus.dc_rdata, k, 32'h2000_0030 + 32'(k));
            end
            tick();
        end
        n_checks++;
        if (bus.dc_done !== 1'b1) begin
            n_fail++;
            $display("FAIL late_d_done: got %0b want 1", bus.dc_done);
        end
        bus.dc_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        logic seen_done;
        wbase       = 32'h0000_B000;
        bus.dc_we   = 1'b1;
        bus.dc_addr = 64'h200;
        bus.dc_req  = 1'b1;
        wait_beat(cyc);
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (bus.mem_write_en !== 1'b1 || bus.dc_idx !== 4'd5) begin
            n_fail++;
            $display("FAIL abort_pre: we %0b idx %0d want 1/5", bus.mem_write_en, bus.dc_idx);
        end
        #2 arstn = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_write_en !== 1'b0 || outs() !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: we %0b outs %h want 0", bus.mem_write_en, outs());
        end
        seen_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_done = seen_done | bus.dc_done;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0b want 0", seen_done);
        end
        bus.dc_req = 1'b0;
        arstn      = 1'b1;
        tick();
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if (mem_d[128 + k] !== ((k < 5) ? 32'hB000 + 32'(k) : 32'h5500 + 32'(k))) begin
                n_fail++;
                $display("FAIL abort_mem word %0d: got %h want %h", k, mem_d[128 + k],
                         (k < 5) ? 32'hB000 + 32'(k) : 32'h5500 + 32'(k));
            end
        end
        bus.dc_we   = 1'b0;
        bus.dc_addr = 64'h204;
        bus.dc_req  = 1'b1;
        wait_beat(cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL abort_rf_latency: got %0d want 3", cyc);
        end
        for (int k = 0; k < BW; k++) begin
            n_checks++;
            if (bus.dc_rvalid !== 1'b1 ||
                bus.dc_rdata !== ((k < 5) ? 32'hB000 + 32'(k) : 32'h5500 + 32'(k))) begin
                n_fail++;
                $display("FAIL abort_rf_beat %0d: valid %0b data %h", k, bus.dc_rvalid, bus.dc_rdata);
            end
            tick();
        end
        n_checks++;
        if (bus.dc_done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rf_done: got %0b want 1", bus.dc_done);
        end
        bus.dc_req = 1'b0;
        tick();
    endtask

    // ----------------------------------------------------------- sequence
    initial begin
        bus.ic_req  = 1'b0;
        bus.ic_addr = '0;
        bus.dc_req  = 1'b0;
        bus.dc_we   = 1'b0;
        bus.dc_addr = '0;
        wbase       = '0;
        test_reset();
        test_i_refill();
        test_d_writeback();
        test_tie();
        test_late_request();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
